dispatch_mem: RTL
=================

Name: dispatch_mem

Overview:
- Dispatch memory stage directly downstream of dispatch control.
- Consumes dmask, dmapbenb and dispwr from dispatch control, plus the rotated M-source bits and the dispatch offset field of IR.
- Forms the dispatch address and holds a 2048 x 17 dispatch RAM. Delivers the next-PC (dpc) and the N/P/R control bits to the PC-select logic.
- Includes a post-reset clear sequencer so the RAM never returns X.

Parameters:
- ADDR_WIDTH, 11, dispatch RAM address width (depth = 2**ADDR_WIDTH).
- CLEAR_ON_RESET, 1, when 1 the clear sequencer runs after reset; when 0 it starts in IDLE and the RAM is uninitialised.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- state_write  input  1  write phase of the microcycle; qualifies RAM writes.
- dispwr  input  1  dispatch-memory write request, from dispatch control.
- dmask  input  7  mask applied to the rotated source bits.
- dmapbenb  input  1  enables merging of the map bits into address bit 0.
- ir  input  49  current microinstruction; uses [22:12] offset and [9:8] map-bit selects.
- r  input  7  low bits of the rotated M source.
- vmo18  input  1  map output bit 18.
- vmo19  input  1  map output bit 19.
- a  input  17  write data for the dispatch RAM (A bus low bits).
- dpc  output  14  dispatch target PC.
- dn  output  1  dispatch N bit (inhibit next).
- dp  output  1  dispatch P bit (push return).
- dr  output  1  dispatch R bit (return).
- busy  output  1  high while the clear sequencer runs.

Behaviour:
- Address (combinational):
  - dadr = ir[22:12] | {4'b0, dmask & r}.
  - When dmapbenb=1, dadr[0] is additionally ORed with (ir[8] & vmo18) | (ir[9] & vmo19).
- RAM word layout: [16]=dr, [15]=dp, [14]=dn, [13:0]=dpc.
- Read:
  - Synchronous, one-cycle latency.
  - Outputs register mem[dadr] on every rising edge when not busy.
  - While busy, outputs hold 0.
- Write:
  - When dispwr & state_write & ~busy, mem[dadr] <= a[16:0] at the edge.
  - Same-cycle read of the written address is write-first: outputs show the new a value the next cycle.
- States: IDLE, CLEAR.
  - reset=1: state <= CLEAR (IDLE if CLEAR_ON_RESET=0), clear counter <= 0, dpc/dn/dp/dr <= 0.
  - CLEAR: each cycle writes 0 to mem[counter] and increments the counter. When counter = 2047 is written, the next state is IDLE and the counter wraps to 0.
  - CLEAR takes exactly 2048 cycles after reset deasserts.
  - busy = (state == CLEAR), combinational from state. busy is 1 in the cycle reset is released.
- Boundaries:
  - reset during CLEAR restarts the counter at 0.
  - dispwr during CLEAR is ignored and not queued.
  - Address OR never carries beyond 11 bits; ir[22:12] = 0x7FF with any r gives 0x7FF.
  - dmapbenb=0 leaves vmo18/vmo19 with no effect.
  - Reset has priority over a write in the same cycle.

Optional Feature:
- Macro: DISPATCH_PARITY_EN.
- When defined:
  - RAM is 18 bits wide; bit 17 stores odd parity over [16:0], computed on write. The clear sequencer writes 0 data with parity bit 1.
  - Extra output dpe (1 bit) is registered with the read data. It is 1 when the stored 18-bit word has even parity, is 0 on reset, and is 0 while busy.
- When undefined: the RAM is 17 bits and the dpe port does not exist.

Test Plan:
- Reset for 2 cycles, release -> busy=1 for exactly 2048 cycles then 0. A read at any address (e.g. 0x000, 0x7FF) then gives dpc=0, dn=dp=dr=0.
- After clear: ir[22:12]=0x123, dmask=0, dispwr=1, state_write=1, a=0x1ABCD -> next-cycle read of 0x123 gives dr=1, dp=1, dn=0, dpc=0x2BCD.
- Offset 0x100, dmask=0x7F, r=0x05 -> dadr=0x105. With dmask=0x04 -> 0x104. With dmapbenb=1, ir[8]=1, vmo18=1 -> 0x105.
- dispwr asserted with state_write=0, or during busy -> RAM unchanged; readback returns the prior value.
- Write a=0x00001 to 0x010 while dadr=0x010 -> the following cycle outputs dpc=0x0001 (write-first). Assert reset at clear count 1000 -> busy lasts a further 2048 cycles.
- DISPATCH_PARITY_EN: write 0x00003, read back -> dpe=0. Force bit 17 of that entry inverted -> dpe=1 on the next read.

Source files
------------

// File: rtl/dispatch_mem.sv
// dispatch_mem: dispatch memory stage that sits after dispatch control.
// Forms the 11-bit dispatch address from the IR offset, masked rotated source
// bits and the optional map bits. Holds the dispatch RAM with a synchronous,
// write-first read port. A clear sequencer zeroes the RAM after reset so reads
// never return X.
// Optional feature macro: DISPATCH_PARITY_EN. When it is defined, the RAM
// stores an odd-parity bit in [17] and the design adds a dpe output.
module dispatch_mem #(
    parameter int ADDR_WIDTH     = 11,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        state_write,
    input  logic        dispwr,
    input  logic [6:0]  dmask,
    input  logic        dmapbenb,
    input  logic [48:0] ir,
    input  logic [6:0]  r,
    input  logic        vmo18,
    input  logic        vmo19,
    input  logic [16:0] a,
    output logic [13:0] dpc,
    output logic        dn,
    output logic        dp,
    output logic        dr,
`ifdef DISPATCH_PARITY_EN
    output logic        dpe,
`endif
    output logic        busy
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
`ifdef DISPATCH_PARITY_EN
    localparam int DW = 18;
`else
    localparam int DW = 17;
`endif

    typedef enum logic {S_IDLE, S_CLEAR} state_t;

    state_t                r_state;
    state_t                w_next;
    logic [ADDR_WIDTH-1:0] r_clr_cnt;
    logic [ADDR_WIDTH-1:0] w_dadr;
    logic [DW-1:0]         r_mem [DEPTH];
    logic [DW-1:0]         r_rdata;
    logic [DW-1:0]         w_wdata;
    logic [DW-1:0]         w_clr_word;
    logic                  w_usr_we;
    logic                  w_map_bit;
    logic                  w_unused;

    // Dispatch address: an OR merge that never carries past the address width.
    always_comb begin
        w_map_bit = dmapbenb & ((ir[8] & vmo18) | (ir[9] & vmo19));
        w_dadr    = ADDR_WIDTH'(ir[22:12]) | ADDR_WIDTH'(dmask & r) | ADDR_WIDTH'(w_map_bit);
    end

    // Write data. The clear word is all zero data, plus a valid parity bit when parity is enabled.
    always_comb begin
`ifdef DISPATCH_PARITY_EN
        w_wdata    = {~^a, a};
        w_clr_word = {1'b1, 17'b0};
`else
        w_wdata    = a;
        w_clr_word = '0;
`endif
    end

    // A user write is only taken outside the clear sweep, and reset blocks it.
    assign w_usr_we = dispwr & state_write & ~busy & ~reset;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) r_state <= CLEAR_ON_RESET ? S_CLEAR : S_IDLE;
        else       r_state <= w_next;
    end

    // FSM next state: leave CLEAR once the last address has been written.
    always_comb begin
        w_next = r_state;
        if (r_state == S_CLEAR && r_clr_cnt == '1) w_next = S_IDLE;
    end

    // FSM outputs.
    always_comb begin
        busy = (r_state == S_CLEAR);
    end

    // Clear counter. It wraps back to 0 when the sweep ends.
    always_ff @(posedge clk) begin
        if (reset)     r_clr_cnt <= '0;
        else if (busy) r_clr_cnt <= r_clr_cnt + 1'b1;
    end

    // RAM write port, shared by the clear sweep and dispatch writes.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (busy)          r_mem[r_clr_cnt] <= w_clr_word;
            else if (w_usr_we) r_mem[w_dadr]    <= w_wdata;
        end
    end

    // Registered read. A write to the same address is forwarded, so the read is write-first.
    always_ff @(posedge clk) begin
        if (reset || busy) r_rdata <= '0;
        else if (w_usr_we) r_rdata <= w_wdata;
        else               r_rdata <= r_mem[w_dadr];
    end

`ifdef DISPATCH_PARITY_EN
    logic r_dpe;
    // Parity error flag, registered together with the read data. It is set when the word has even parity.
    always_ff @(posedge clk) begin
        if (reset || busy) r_dpe <= 1'b0;
        else if (w_usr_we) r_dpe <= ~^w_wdata;
        else               r_dpe <= ~^r_mem[w_dadr];
    end
    assign dpe = r_dpe;
`endif

    assign dr  = r_rdata[16];
    assign dp  = r_rdata[15];
    assign dn  = r_rdata[14];
    assign dpc = r_rdata[13:0];

    assign w_unused = &{1'b0, ir[48:23], ir[11:10], ir[7:0], r_rdata[DW-1]};

endmodule
